run_result_checker: RTL and testbench

//  Synthesizable, parametrised end-of-run checker for the CHIP. It watches the instruction

---
 rtl/run_result_checker_pkg.sv | 17 +
 rtl/run_result_checker_if.sv | 36 +++
 rtl/run_result_checker_rd_lat_pipe.sv | 42 ++++
 rtl/run_result_checker.sv | 166 ++++++++++++++++
 tb/tb_run_result_checker.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_result_checker_pkg.sv
// Shared types and helpers for the end-of-run result checker.
package run_result_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/run_result_checker_if.sv
// Control, memory-read and result signals between the checker and its environment.
interface run_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
);
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] eof_addr;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] cmp_mask;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] dut_rdata;
  logic [DATA_W-1:0] gold_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [IDX_W-1:0]  err_cnt;
  logic [IDX_W-1:0]  first_err_idx;
  logic              first_err_vld;

  modport master (
    output start, pc, eof_addr, base_addr, cmp_mask, dut_rdata, gold_rdata,
    input  rd_en, rd_addr, rd_idx, busy, done, pass, timeout,
           err_cnt, first_err_idx, first_err_vld
  );

  modport slave (
    input  start, pc, eof_addr, base_addr, cmp_mask, dut_rdata, gold_rdata,
    output rd_en, rd_addr, rd_idx, busy, done, pass, timeout,
           err_cnt, first_err_idx, first_err_vld
  );
endinterface

// File: rtl/run_result_checker_rd_lat_pipe.sv
// Delays {valid, index} of each read by the memory latency so returning data
// lines up with the word index it belongs to.
module run_result_checker_rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_vld_o,
  output logic [IDX_W-1:0] out_idx_o
);

  if (RD_LAT == 0) begin : g_thru
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_vld_o      = in_vld_i;
    assign out_idx_o      = in_idx_i;
  end else begin : g_pipe
    logic [RD_LAT-1:0]            vld_pipe_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe_q <= '0;
        idx_pipe_q <= '0;
      end else begin
        vld_pipe_q[0] <= in_vld_i;
        idx_pipe_q[0] <= in_idx_i;
        for (int s = 1; s < RD_LAT; s++) begin
          vld_pipe_q[s] <= vld_pipe_q[s-1];
          idx_pipe_q[s] <= idx_pipe_q[s-1];
        end
      end
    end

    assign out_vld_o = vld_pipe_q[RD_LAT-1];
    assign out_idx_o = idx_pipe_q[RD_LAT-1];
  end

endmodule

// File: rtl/run_result_checker.sv
// End-of-run checker: waits for the program to reach its end address under a
// cycle watchdog, then compares DEPTH data words against a golden image.
module run_result_checker
  import run_result_checker_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 32,
  parameter int MAX_CYCLES = 1000,
  parameter int RD_LAT     = 1
) (
  input logic                 clk,
  input logic                 rst,
  run_result_checker_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int CYC_W = cnt_w(MAX_CYCLES);
  localparam int BYTES = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] eof_q, eof_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  ferr_idx_q, ferr_idx_d;
  logic              ferr_vld_q, ferr_vld_d;
  logic              pass_q, pass_d;
  logic              tout_q, tout_d;

  logic              rd_en;
  logic              ret_vld;
  logic [IDX_W-1:0]  ret_idx;
  logic              mis;

  assign rd_en = (state_q == ST_SCAN);

  run_result_checker_rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (rd_en),
    .in_idx_i  (idx_q),
    .out_vld_o (ret_vld),
    .out_idx_o (ret_idx)
  );

  assign mis = ret_vld && |((bus.dut_rdata ^ bus.gold_rdata) & mask_q);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    eof_d      = eof_q;
    base_d     = base_q;
    mask_d     = mask_q;
    err_d      = err_q;
    ferr_idx_d = ferr_idx_q;
    ferr_vld_d = ferr_vld_q;
    pass_d     = pass_q;
    tout_d     = tout_q;

    // Returns are compared in whatever state they arrive (SCAN or DRAIN).
    if (mis) begin
      if (err_q != IDX_W'(DEPTH)) err_d = err_q + IDX_W'(1);
      if (!ferr_vld_q) begin
        ferr_vld_d = 1'b1;
        ferr_idx_d = ret_idx;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          eof_d      = bus.eof_addr;
          base_d     = bus.base_addr;
          mask_d     = bus.cmp_mask;
          cyc_d      = '0;
          idx_d      = '0;
          err_d      = '0;
          ferr_idx_d = '0;
          ferr_vld_d = 1'b0;
          pass_d     = 1'b0;
          tout_d     = 1'b0;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        // End-of-program takes priority over a watchdog expiring on the same cycle.
        if (bus.pc == eof_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else if (cyc_q == CYC_W'(MAX_CYCLES - 1)) begin
          state_d = ST_DONE;
          tout_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (idx_q == LAST_IDX) begin
          if (RD_LAT == 0) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ret_vld && ret_idx == LAST_IDX) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      idx_q      <= '0;
      eof_q      <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      err_q      <= '0;
      ferr_idx_q <= '0;
      ferr_vld_q <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      eof_q      <= eof_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_vld_q <= ferr_vld_d;
      pass_q     <= pass_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.rd_en         = rd_en;
  assign bus.rd_idx        = idx_q;
  assign bus.rd_addr       = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);
  assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.pass          = pass_q;
  assign bus.timeout       = tout_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = ferr_idx_q;
  assign bus.first_err_vld = ferr_vld_q;

endmodule

// File: tb/tb_run_result_checker.sv
// Drives four checkers (read latency 0..3) with identical runs and checks each
// against a word-by-word reference of the golden compare.
module tb_run_result_checker;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 32;
  localparam int MAXC   = 1000;
  localparam int NI     = 4;
  localparam int IDX_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] pc, eof_addr, base_addr;
  logic [DATA_W-1:0] cmp_mask;
  logic [DATA_W-1:0] dmem [64];
  logic [DATA_W-1:0] gmem [64];

  logic              done_a [NI], pass_a [NI], tout_a [NI], fvld_a [NI], busy_a [NI], rden_a [NI];
  logic [IDX_W-1:0]  err_a [NI], fidx_a [NI], rdidx_a [NI];
  logic [ADDR_W-1:0] rdaddr_a [NI];
  logic [31:0]       rdcnt_a [NI], bad_a [NI];
  int                lat_a [NI];
  int                n_tests = 0;
  int                n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    run_result_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();
    logic [IDX_W-1:0] ai;
    logic [IDX_W-1:0] dp [4];
    logic [IDX_W-1:0] gp [4];
    logic [31:0]      rd_cnt, bad;

    assign bus.start     = start;
    assign bus.pc        = pc;
    assign bus.eof_addr  = eof_addr;
    assign bus.base_addr = base_addr;
    assign bus.cmp_mask  = cmp_mask;

    // Data memory is addressed by byte address, golden memory by word index.
    assign ai = IDX_W'((bus.rd_addr - base_addr) >> 2);
    always @(posedge clk) begin
      dp[0] <= ai;
      gp[0] <= bus.rd_idx;
      for (int k = 1; k < 4; k++) begin
        dp[k] <= dp[k-1];
        gp[k] <= gp[k-1];
      end
    end
    assign bus.dut_rdata  = (g == 0) ? dmem[ai]         : dmem[dp[(g == 0) ? 0 : g-1]];
    assign bus.gold_rdata = (g == 0) ? gmem[bus.rd_idx] : gmem[gp[(g == 0) ? 0 : g-1]];

    always @(posedge clk) begin
      if (rst || start) begin
        rd_cnt <= 0;
        bad    <= 0;
      end else if (bus.rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (32'(bus.rd_idx) != rd_cnt || bus.rd_addr != base_addr + 32'(bus.rd_idx) * 4)
          bad <= bad + 1;
      end
    end

    assign done_a[g]   = bus.done;
    assign pass_a[g]   = bus.pass;
    assign tout_a[g]   = bus.timeout;
    assign fvld_a[g]   = bus.first_err_vld;
    assign busy_a[g]   = bus.busy;
    assign rden_a[g]   = bus.rd_en;
    assign err_a[g]    = bus.err_cnt;
    assign fidx_a[g]   = bus.first_err_idx;
    assign rdidx_a[g]  = bus.rd_idx;
    assign rdaddr_a[g] = bus.rd_addr;
    assign rdcnt_a[g]  = rd_cnt;
    assign bad_a[g]    = bad;

    run_result_checker #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .RD_LAT(g)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- reference model ----------------
  function automatic int exp_errs(input logic [31:0] mask);
    int c = 0;
    for (int k = 0; k < DEPTH; k++) if (((dmem[k] ^ gmem[k]) & mask) != 0) c++;
    return c;
  endfunction

  function automatic int exp_first(input logic [31:0] mask);
    for (int k = 0; k < DEPTH; k++) if (((dmem[k] ^ gmem[k]) & mask) != 0) return k;
    return 0;
  endfunction

  // {done, pass, timeout, first_err_vld, err_cnt, first_err_idx}
  function automatic logic [15:0] exp_scan(input logic [31:0] mask);
    int e = exp_errs(mask);
    return {1'b1, e == 0, 1'b0, e != 0, IDX_W'(e), IDX_W'(exp_first(mask))};
  endfunction

  function automatic logic [15:0] res(input int k);
    return {done_a[k], pass_a[k], tout_a[k], fvld_a[k], err_a[k], fidx_a[k]};
  endfunction

  function automatic logic [55:0] outs(input int k);
    return {done_a[k], busy_a[k], pass_a[k], tout_a[k], fvld_a[k], rden_a[k],
            err_a[k], fidx_a[k], rdidx_a[k], rdaddr_a[k]};
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p = $urandom;
    if (p == eof_addr) p = ~p;
    return p;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_equal();
    for (int k = 0; k < 64; k++) begin
      gmem[k] = $urandom;
      dmem[k] = gmem[k];
    end
  endtask

  task automatic launch(input logic [31:0] eof, input logic [31:0] base, input logic [31:0] mask);
    @(negedge clk);
    eof_addr  = eof;
    base_addr = base;
    cmp_mask  = mask;
    pc        = eof ^ 32'h1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // n counts rising edges after the start edge; pc equals eof_addr for the cycle after edge eof_at.
  task automatic run_to_done(input int eof_at, input int pulse_at);
    int n = 0;
    int ndone;
    logic [31:0] keep = cmp_mask;
    for (int k = 0; k < NI; k++) lat_a[k] = -1;
    while (n < 1200) begin
      ndone = 0;
      for (int k = 0; k < NI; k++) if (done_a[k]) begin
        if (lat_a[k] < 0) lat_a[k] = n;
        ndone++;
      end
      if (ndone == NI) break;
      pc       = (n == eof_at) ? eof_addr : rand_pc();
      start    = (n == pulse_at);
      cmp_mask = (n == pulse_at) ? 32'h0 : keep;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start    = 1'b0;
    cmp_mask = keep;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pc = '0; eof_addr = '0; base_addr = '0; cmp_mask = '0;
    fill_equal();
    #3;
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (outs(k) !== '0) begin
        n_fail++; $display("FAIL reset_outputs[L=%0d]: got %h want 0", k, outs(k));
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_equal();
    logic [15:0] ex;
    fill_equal();
    launch(32'h0000_2000, 32'hFFFF_FFC0, '1);
    ex = exp_scan('1);
    run_to_done(40, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests += 3;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL equal_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
      if (lat_a[k] != 40 + DEPTH + 1 + k) begin
        n_fail++; $display("FAIL equal_latency[L=%0d]: got %0d want %0d", k, lat_a[k], 40 + DEPTH + 1 + k);
      end
      if (rdcnt_a[k] != DEPTH || bad_a[k] != 0) begin
        n_fail++; $display("FAIL equal_reads[L=%0d]: got %0d reads %0d bad want %0d reads 0 bad", k, rdcnt_a[k], bad_a[k], DEPTH);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [15:0] ex;
    fill_equal();
    gmem[5]  = 32'h0000_0001;
    dmem[5]  = 32'h0000_0002;
    dmem[17] = gmem[17] ^ 32'h0001_0000;
    launch(32'h0000_0400, 32'h0000_1000, '1);
    ex = exp_scan('1);
    run_to_done(12, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests += 2;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL mismatch_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
      if (lat_a[k] != 12 + DEPTH + 1 + k) begin
        n_fail++; $display("FAIL mismatch_latency[L=%0d]: got %0d want %0d", k, lat_a[k], 12 + DEPTH + 1 + k);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] ex = {4'b1010, IDX_W'(0), IDX_W'(0)};
    fill_equal();
    dmem[3] = ~gmem[3];
    launch(32'hDEAD_0000, 32'h0, '1);
    run_to_done(-1, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests += 3;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL timeout_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
      if (lat_a[k] != MAXC) begin
        n_fail++; $display("FAIL timeout_latency[L=%0d]: got %0d want %0d", k, lat_a[k], MAXC);
      end
      if (rdcnt_a[k] != 0) begin
        n_fail++; $display("FAIL timeout_reads[L=%0d]: got %0d want 0", k, rdcnt_a[k]);
      end
    end
  endtask

  task automatic test_eof_wins();
    logic [15:0] ex;
    fill_equal();
    dmem[9] = gmem[9] ^ 32'h0000_0100;
    launch(32'h0000_7777, 32'h0000_0100, '1);
    ex = exp_scan('1);
    run_to_done(MAXC - 1, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests += 2;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL eof_wins_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
      if (lat_a[k] != MAXC - 1 + DEPTH + 1 + k) begin
        n_fail++; $display("FAIL eof_wins_latency[L=%0d]: got %0d want %0d", k, lat_a[k], MAXC + DEPTH + k);
      end
    end
  endtask

  task automatic test_mask();
    logic [15:0] ex;
    fill_equal();
    for (int k = 0; k < DEPTH; k++) dmem[k] = gmem[k] ^ (($urandom & 32'h0000_FFFF) | 32'h1);
    launch(32'h0000_0800, 32'h0001_0000, 32'hFFFF_0000);
    ex = exp_scan(32'hFFFF_0000);
    run_to_done(7, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (res(k) !== ex || pass_a[k] !== 1'b1) begin
        n_fail++; $display("FAIL mask_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
    end
  endtask

  task automatic test_last_idx();
    logic [15:0] ex;
    fill_equal();
    dmem[DEPTH-1] = gmem[DEPTH-1] ^ 32'h8000_0000;
    launch(32'h0000_0C00, 32'h0000_2000, '1);
    ex = exp_scan('1);
    run_to_done(10, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL last_idx_result[L=%0d]: got %h want %h", k, res(k), ex);
      end
    end
  endtask

  task automatic test_reset_scan();
    int n = 0;
    logic [15:0] ex;
    fill_equal();
    launch(32'h0000_0044, 32'h0000_0100, '1);
    while (!(rden_a[0] && rdidx_a[0] == IDX_W'(10)) && n < 100) begin
      pc = (n == 0) ? eof_addr : rand_pc();
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 100) begin
      n_fail++; $display("FAIL reset_scan_reach_idx10: got no scan want idx 10");
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (outs(k) !== '0) begin
        n_fail++; $display("FAIL reset_scan_outputs[L=%0d]: got %h want 0", k, outs(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    dmem[20] = gmem[20] ^ 32'h0000_0040;
    launch(32'h0000_0044, 32'h0000_0100, '1);
    ex = exp_scan('1);
    run_to_done(5, -1);
    for (int k = 0; k < NI; k++) begin
      n_tests += 2;
      if (res(k) !== ex) begin
        n_fail++; $display("FAIL reset_scan_rerun[L=%0d]: got %h want %h", k, res(k), ex);
      end
      if (rdcnt_a[k] != DEPTH || bad_a[k] != 0) begin
        n_fail++; $display("FAIL reset_scan_reads[L=%0d]: got %0d reads %0d bad", k, rdcnt_a[k], bad_a[k]);
      end
    end
  endtask

  // Re-arm straight from DONE; a start pulse (with a zero mask) during RUN must be ignored.
  task automatic test_back_to_back();
    logic [15:0] ex;
    for (int r = 0; r < 3; r++) begin
      fill_equal();
      if (r == 1) begin
        dmem[2]  = gmem[2] ^ 32'h0000_0010;
        dmem[30] = gmem[30] ^ 32'h1000_0000;
      end
      launch(32'h0000_1234 + r, 32'h0000_4000, '1);
      ex = exp_scan('1);
      run_to_done(20, 5);
      for (int k = 0; k < NI; k++) begin
        n_tests += 2;
        if (res(k) !== ex) begin
          n_fail++; $display("FAIL b2b_result[run%0d L=%0d]: got %h want %h", r, k, res(k), ex);
        end
        if (lat_a[k] != 20 + DEPTH + 1 + k) begin
          n_fail++; $display("FAIL b2b_latency[run%0d L=%0d]: got %0d want %0d", r, k, lat_a[k], 20 + DEPTH + 1 + k);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ex;
    logic [31:0] mask;
    int eof_at;
    for (int it = 0; it < 5; it++) begin
      fill_equal();
      for (int k = 0; k < DEPTH; k++)
        if ($urandom_range(0, 3) == 0) dmem[k] = gmem[k] ^ (32'h1 << $urandom_range(0, 31));
      mask   = (it == 0) ? 32'hFFFF_FFFF : $urandom;
      eof_at = $urandom_range(1, 80);
      launch($urandom, $urandom & 32'hFFFF_FFFC, mask);
      ex = exp_scan(mask);
      run_to_done(eof_at, -1);
      for (int k = 0; k < NI; k++) begin
        n_tests += 3;
        if (res(k) !== ex) begin
          n_fail++; $display("FAIL random_result[it%0d L=%0d]: got %h want %h", it, k, res(k), ex);
        end
        if (lat_a[k] != eof_at + DEPTH + 1 + k) begin
          n_fail++; $display("FAIL random_latency[it%0d L=%0d]: got %0d want %0d", it, k, lat_a[k], eof_at + DEPTH + 1 + k);
        end
        if (rdcnt_a[k] != DEPTH || bad_a[k] != 0) begin
          n_fail++; $display("FAIL random_reads[it%0d L=%0d]: got %0d reads %0d bad", it, k, rdcnt_a[k], bad_a[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_mismatch();
    test_timeout();
    test_eof_wins();
    test_mask();
    test_last_idx();
    test_reset_scan();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1);
  end

endmodule
